pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the in-order RISC-V core.
- Sits between the stage datapaths and the pipeline registers (if_id, id_exe, exe_mem, mem_wb, ...) and the pc register.
- Arbitrates per-stage stall requests against redirect (jump/branch/trap) requests.
- Drives per-register stall, bubble and flush vectors, plus a registered redirect strobe and target for pc_reg.

Parameters:
- NREG, 4, number of pipeline registers; index 0 = if_id, index NREG-1 = last.
- ADDR_W, 32, redirect target width.
- FLUSH_CYC, 1, cycles flush_o is held per redirect (1..15).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; synchronous, active-low.
- stall_req_i  in  NREG  bit k: pipeline register k must hold its contents.
- redirect_i  in  1  jump/branch taken or trap, valid this cycle.
- redirect_src_i  in  $clog2(NREG+1)  redirecting stage; registers 0..src-1 are younger.
- redirect_pc_i  in  ADDR_W  redirect target.
- stall_o  out  NREG  hold enable per pipeline register.
- bubble_o  out  NREG  insert NOP into pipeline register this cycle.
- flush_o  out  NREG  clear pipeline register.
- jumpe_o  out  1  pc_reg loads jump_pc_o.
- jump_pc_o  out  ADDR_W  redirect target to pc_reg.
- busy_o  out  1  state != RUN.

Behaviour:
- Reset (rst_i==0 at a posedge): state=RUN; flush_o, jumpe_o, jump_pc_o, pending registers and counter all 0.
- Reset outputs, combinational: stall_o=0, bubble_o=0.
- Reset mid-FLUSH or mid-PEND discards the latched redirect.
- Stall, combinational (zero latency):
  - k = highest set bit of stall_req_i.
  - stall_o[j]=1 for all j<=k.
  - bubble_o[k+1]=1 if k+1<NREG.
  - No request: all zero.
- Redirect, registered (one-cycle latency, as for the existing jump path).
- FSM states RUN, PEND, FLUSH.
- RUN:
  - redirect_i with k<redirect_src_i, or no stall:
    - Next cycle: jumpe_o=1 for exactly one cycle, jump_pc_o=redirect_pc_i, flush_o[j]=1 for j<redirect_src_i.
    - Go to FLUSH with cnt=FLUSH_CYC-1.
    - Stall requests from flushed registers are masked (stall_o and bubble_o forced 0 for j<src).
  - redirect_i with k>=redirect_src_i (an older stage is stalled):
    - Latch pc and src; go to PEND.
    - The redirecting instruction is held by the stall.
- PEND:
  - Hold the latched values.
  - New redirect_i is ignored (no younger redirect is possible while src is stalled).
  - First cycle with k<latched src: issue as in RUN, then go to FLUSH.
- FLUSH:
  - flush_o is held on the latched mask while cnt!=0; cnt decrements each cycle.
  - Return to RUN when cnt==0 with flush_o deasserting.
  - FLUSH_CYC=1: flush_o is high for exactly one cycle, coincident with jumpe_o.
  - redirect_i with src > latched src (older stage) preempts: re-issue with the new target and mask, restart cnt.
  - Otherwise redirect_i is ignored (it comes from a flushed instruction).
- Simultaneous stall and redirect in the same cycle resolve by the src-versus-k rule above.
- redirect_src_i > NREG: treated as NREG (flush all registers).
- redirect_src_i == 0: jumpe_o only, no flush.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - Adds outputs stall_cnt_o[31:0] (increments each cycle stall_o!=0) and flush_cnt_o[31:0] (increments each jumpe_o pulse).
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (existing defines header) gains:
  - State encodings PH_RUN=2'd0, PH_PEND=2'd1, PH_FLUSH=2'd2.
  - `FlushEnable/`FlushDisable and `JumpEnable reused for 1-bit levels.
- Sub-module stall_prio_enc (leading-one encoder plus mask generation, combinational, parametrised on NREG), instantiated once for stall and reused for the flush mask.

Test Plan:
- NREG=4. redirect_i=1, src=3, pc=0x100, no stall -> next cycle jumpe_o=1, jump_pc_o=0x100, flush_o=4'b0111 for 1 cycle; then RUN.
- stall_req_i=4'b0010, no redirect -> same cycle stall_o=4'b0011, bubble_o=4'b0100, flush_o=0.
- stall_req_i=4'b1000 for 3 cycles with redirect src=2 pc=0x200 in cycle 0 -> PEND, busy_o=1, no jumpe_o; cycle after stall drops: jumpe_o=1, pc 0x200, flush_o=4'b0011.
- FLUSH_CYC=3, redirect src=3 -> flush_o=4'b0111 held 3 cycles, jumpe_o 1 cycle; redirect src=4 pc=0x300 in 2nd cycle -> new jumpe_o, flush_o=4'b1111, cnt restarts.
- rst_i=0 asserted during PEND -> next cycle all outputs 0, state RUN, latched redirect never issued.
- PIPE_HAZARD_CTRL_PERF_EN: 5 stall cycles plus 2 redirects -> stall_cnt_o=5, flush_cnt_o=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, 1-bit enable levels and the flush counter width.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        PH_RUN   = 2'd0,
        PH_PEND  = 2'd1,
        PH_FLUSH = 2'd2
    } ph_state_e;

    localparam logic FlushEnable  = 1'b1;
    localparam logic FlushDisable = 1'b0;
    localparam logic JumpEnable   = 1'b1;
    localparam logic JumpDisable  = 1'b0;

    // Wide enough for FLUSH_CYC up to 15
    localparam int unsigned PH_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_prio_enc.sv
// Leading-one encoder: marks every bit at or below the highest request
// and one-hot flags the position just above it.
module pipe_hazard_ctrl_stall_prio_enc
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 4
) (
    input  logic [NREG-1:0] req_i,
    output logic [NREG-1:0] le_mask_o,
    output logic [NREG-1:0] next_o
);

    always_comb begin
        le_mask_o = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            le_mask_o[i] = |(req_i >> i);
        end
    end

    // Bit k+1 is the first cleared position above a set thermometer bit
    always_comb begin
        next_o = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            next_o[i] = le_mask_o[i-1] & ~le_mask_o[i];
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/bubble, registered redirect
// with flush. Optional perf counters under `PIPE_HAZARD_CTRL_PERF_EN`.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NREG      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned FLUSH_CYC = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NREG-1:0]             stall_req_i,
    input  logic                        redirect_i,
    input  logic [$clog2(NREG+1)-1:0]   redirect_src_i,
    input  logic [ADDR_W-1:0]           redirect_pc_i,
    output logic [NREG-1:0]             stall_o,
    output logic [NREG-1:0]             bubble_o,
    output logic [NREG-1:0]             flush_o,
    output logic                        jumpe_o,
    output logic [ADDR_W-1:0]           jump_pc_o,
    output logic                        busy_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]                 stall_cnt_o,
    output logic [31:0]                 flush_cnt_o
`endif
);

    localparam int unsigned SRC_W = $clog2(NREG + 1);
    localparam logic [SRC_W-1:0] SRC_MAX = SRC_W'(NREG);
    localparam logic [PH_CNT_W-1:0] CNT_INIT = PH_CNT_W'(FLUSH_CYC - 1);

    ph_state_e             state_q, state_d;
    logic [PH_CNT_W-1:0]   cnt_q, cnt_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     jpc_q, jpc_d;
    logic                  jumpe_q, jumpe_d;
    logic [NREG-1:0]       flush_q, flush_d;

    logic [SRC_W-1:0]      src_in, src_sel;
    logic [NREG-1:0]       src_onehot, src_mask, flush_nx_unused;
    logic [NREG-1:0]       stall_eff, stall_le, stall_nx;
    logic [ADDR_W-1:0]     issue_pc;
    logic                  issue_ok, do_issue, do_latch;

    assign src_in  = (redirect_src_i > SRC_MAX) ? SRC_MAX : redirect_src_i;
    assign src_sel = (state_q == PH_PEND) ? src_q : src_in;
    assign issue_pc = (state_q == PH_PEND) ? pc_q : redirect_pc_i;

    // Flushed registers cannot hold the pipe
    assign stall_eff = stall_req_i & ~flush_q;

    always_comb begin
        src_onehot = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            src_onehot[i] = (src_sel == SRC_W'(i + 1));
        end
    end

    pipe_hazard_ctrl_stall_prio_enc #(.NREG(NREG)) u_stall_enc (
        .req_i     (stall_eff),
        .le_mask_o (stall_le),
        .next_o    (stall_nx)
    );

    // One-hot at src-1 yields the thermometer mask of registers younger than src
    pipe_hazard_ctrl_stall_prio_enc #(.NREG(NREG)) u_flush_enc (
        .req_i     (src_onehot),
        .le_mask_o (src_mask),
        .next_o    (flush_nx_unused)
    );

    // Redirect may issue only if no stalled register lies at or above src
    assign issue_ok = ((stall_le & ~src_mask) == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        pc_d     = pc_q;
        jpc_d    = jpc_q;
        jumpe_d  = JumpDisable;
        flush_d  = flush_q;
        do_issue = 1'b0;
        do_latch = 1'b0;

        case (state_q)
            PH_RUN: begin
                if (redirect_i) begin
                    do_issue = issue_ok;
                    do_latch = !issue_ok;
                end
            end
            PH_PEND: begin
                do_issue = issue_ok;
            end
            PH_FLUSH: begin
                if (redirect_i && (src_in > src_q)) begin
                    do_issue = issue_ok;
                    do_latch = !issue_ok;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - PH_CNT_W'(1);
                end else begin
                    state_d = PH_RUN;
                    flush_d = {NREG{FlushDisable}};
                end
            end
            default: begin
                state_d = PH_RUN;
                flush_d = {NREG{FlushDisable}};
            end
        endcase

        if (do_issue) begin
            state_d = PH_FLUSH;
            cnt_d   = CNT_INIT;
            src_d   = src_sel;
            jpc_d   = issue_pc;
            jumpe_d = JumpEnable;
            flush_d = src_mask;
        end else if (do_latch) begin
            state_d = PH_PEND;
            src_d   = src_in;
            pc_d    = redirect_pc_i;
            flush_d = {NREG{FlushDisable}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= PH_RUN;
            cnt_q   <= '0;
            src_q   <= '0;
            pc_q    <= '0;
            jpc_q   <= '0;
            jumpe_q <= JumpDisable;
            flush_q <= {NREG{FlushDisable}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            pc_q    <= pc_d;
            jpc_q   <= jpc_d;
            jumpe_q <= jumpe_d;
            flush_q <= flush_d;
        end
    end

    assign stall_o   = rst_i ? stall_le : '0;
    assign bubble_o  = rst_i ? stall_nx : '0;
    assign flush_o   = flush_q;
    assign jumpe_o   = jumpe_q;
    assign jump_pc_o = jpc_q;
    assign busy_o    = (state_q != PH_RUN);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o != '0) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (jumpe_q) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: instance A uses FLUSH_CYC=1,
// instance B uses FLUSH_CYC=3; registered outputs checked via a scoreboard.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        jumpe;
        logic [31:0] pc;
        logic [3:0]  flush;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  stall_a, stall_b;
    logic        redir_a, redir_b;
    logic [2:0]  src_a, src_b;
    logic [31:0] pc_a, pc_b;

    logic [3:0]  stall_o_a, bubble_o_a, flush_o_a;
    logic [3:0]  stall_o_b, bubble_o_b, flush_o_b;
    logic        jumpe_a, jumpe_b, busy_a, busy_b;
    logic [31:0] jpc_a, jpc_b;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_hazard_ctrl #(.NREG(4), .ADDR_W(32), .FLUSH_CYC(1)) dut_a (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .stall_req_i    (stall_a),
        .redirect_i     (redir_a),
        .redirect_src_i (src_a),
        .redirect_pc_i  (pc_a),
        .stall_o        (stall_o_a),
        .bubble_o       (bubble_o_a),
        .flush_o        (flush_o_a),
        .jumpe_o        (jumpe_a),
        .jump_pc_o      (jpc_a),
        .busy_o         (busy_a)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt_o    (scnt_a),
        .flush_cnt_o    (fcnt_a)
`endif
    );

    pipe_hazard_ctrl #(.NREG(4), .ADDR_W(32), .FLUSH_CYC(3)) dut_b (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .stall_req_i    (stall_b),
        .redirect_i     (redir_b),
        .redirect_src_i (src_b),
        .redirect_pc_i  (pc_b),
        .stall_o        (stall_o_b),
        .bubble_o       (bubble_o_b),
        .flush_o        (flush_o_b),
        .jumpe_o        (jumpe_b),
        .jump_pc_o      (jpc_b),
        .busy_o         (busy_b)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt_o    (scnt_b),
        .flush_cnt_o    (fcnt_b)
`endif
    );

    task automatic drive_a(input logic [3:0] st, input logic rd, input logic [2:0] s, input logic [31:0] p);
        stall_a = st; redir_a = rd; src_a = s; pc_a = p;
    endtask

    task automatic drive_b(input logic [3:0] st, input logic rd, input logic [2:0] s, input logic [31:0] p);
        stall_b = st; redir_b = rd; src_b = s; pc_b = p;
    endtask

    task automatic test_reset();
        exp_t obs;
        rst_n = 1'b0;
        drive_a(4'b0110, 1'b1, 3'd2, 32'h77);
        drive_b(4'b0001, 1'b1, 3'd3, 32'h88);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                rst_n = 1'b1;
                drive_a(4'b0000, 1'b0, 3'd0, 32'h0);
                drive_b(4'b0000, 1'b0, 3'd0, 32'h0);
            end else begin
                #1;
                n_checks++;
                if ({stall_o_a, bubble_o_a, stall_o_b, bubble_o_b} !== 16'h0) begin
                    n_fail++;
                    $display("FAIL reset_comb c%0d: got %h expected 0000", c,
                             {stall_o_a, bubble_o_a, stall_o_b, bubble_o_b});
                end
            end
            obs = '{jumpe_a, jpc_a, flush_o_a, busy_a};
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_regs_a c%0d: got %h expected 0", c, obs);
            end
            obs = '{jumpe_b, jpc_b, flush_o_b, busy_b};
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_regs_b c%0d: got %h expected 0", c, obs);
            end
        end
    endtask

    // Plain redirects, including src clamping above NREG and src == 0
    task automatic test_redirect();
        logic        rd [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  sr [6] = '{3'd3, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
        logic [31:0] pc [6] = '{32'h100, 32'h0, 32'h140, 32'h0, 32'h160, 32'h0};
        exp_t        ex [6] = '{'{1'b1, 32'h100, 4'b0111, 1'b1}, '{1'b0, 32'h100, 4'b0000, 1'b0},
                               '{1'b1, 32'h140, 4'b1111, 1'b1}, '{1'b0, 32'h140, 4'b0000, 1'b0},
                               '{1'b1, 32'h160, 4'b0000, 1'b1}, '{1'b0, 32'h160, 4'b0000, 1'b0}};
        exp_t e, obs;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb_q.pop_front();
                obs = '{jumpe_a, jpc_a, flush_o_a, busy_a};
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL redirect c%0d: got %h expected %h", c, obs, e);
                end
            end
            if (c < 6) begin
                drive_a(4'b0000, rd[c], sr[c], pc[c]);
                sb_q.push_back(ex[c]);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] st [5] = '{4'b0010, 4'b1000, 4'b0001, 4'b0101, 4'b0000};
        logic [7:0] cb [5] = '{8'b0011_0100, 8'b1111_0000, 8'b0001_0010, 8'b0111_1000, 8'b0000_0000};
        exp_t e, obs;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb_q.pop_front();
                obs = '{jumpe_a, jpc_a, flush_o_a, busy_a};
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL stall_regs c%0d: got %h expected %h", c, obs, e);
                end
            end
            if (c < 5) begin
                drive_a(st[c], 1'b0, 3'd0, 32'h0);
                sb_q.push_back('{1'b0, 32'h160, 4'b0000, 1'b0});
                #1;
                n_checks++;
                if ({stall_o_a, bubble_o_a} !== cb[c]) begin
                    n_fail++;
                    $display("FAIL stall_comb c%0d: got %b expected %b", c, {stall_o_a, bubble_o_a}, cb[c]);
                end
            end
        end
    endtask

    // Redirect behind an older stall, then a redirect racing a younger stall
    task automatic test_pend();
        logic [3:0]  st [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0000};
        logic        rd [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  sr [8] = '{3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0};
        logic [31:0] pc [8] = '{32'h200, 32'h0, 32'h999, 32'h0, 32'h0, 32'h240, 32'h0, 32'h0};
        logic [7:0]  cb [8] = '{8'b1111_0000, 8'b1111_0000, 8'b1111_0000, 8'h00,
                                8'h00, 8'b0001_0010, 8'h00, 8'h00};
        exp_t        ex [8] = '{'{1'b0, 32'h160, 4'b0000, 1'b1}, '{1'b0, 32'h160, 4'b0000, 1'b1},
                               '{1'b0, 32'h160, 4'b0000, 1'b1}, '{1'b1, 32'h200, 4'b0011, 1'b1},
                               '{1'b0, 32'h200, 4'b0000, 1'b0}, '{1'b1, 32'h240, 4'b0111, 1'b1},
                               '{1'b0, 32'h240, 4'b0000, 1'b0}, '{1'b0, 32'h240, 4'b0000, 1'b0}};
        exp_t e, obs;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb_q.pop_front();
                obs = '{jumpe_a, jpc_a, flush_o_a, busy_a};
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL pend c%0d: got %h expected %h", c, obs, e);
                end
            end
            if (c < 8) begin
                drive_a(st[c], rd[c], sr[c], pc[c]);
                sb_q.push_back(ex[c]);
                #1;
                n_checks++;
                if ({stall_o_a, bubble_o_a} !== cb[c]) begin
                    n_fail++;
                    $display("FAIL pend_comb c%0d: got %b expected %b", c, {stall_o_a, bubble_o_a}, cb[c]);
                end
            end
        end
    endtask

    // FLUSH_CYC=3: held flush, older-stage preemption, younger redirect ignored
    task automatic test_flush_multi();
        logic        rd [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  sr [10] = '{3'd3, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd4, 3'd2, 3'd0, 3'd0};
        logic [31:0] pc [10] = '{32'h180, 32'h0, 32'h0, 32'h0, 32'h1c0, 32'h0, 32'h300, 32'h3f0, 32'h0, 32'h0};
        exp_t        ex [10] = '{'{1'b1, 32'h180, 4'b0111, 1'b1}, '{1'b0, 32'h180, 4'b0111, 1'b1},
                                '{1'b0, 32'h180, 4'b0111, 1'b1}, '{1'b0, 32'h180, 4'b0000, 1'b0},
                                '{1'b1, 32'h1c0, 4'b0111, 1'b1}, '{1'b0, 32'h1c0, 4'b0111, 1'b1},
                                '{1'b1, 32'h300, 4'b1111, 1'b1}, '{1'b0, 32'h300, 4'b1111, 1'b1},
                                '{1'b0, 32'h300, 4'b1111, 1'b1}, '{1'b0, 32'h300, 4'b0000, 1'b0}};
        exp_t e, obs;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb_q.pop_front();
                obs = '{jumpe_b, jpc_b, flush_o_b, busy_b};
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL flush_multi c%0d: got %h expected %h", c, obs, e);
                end
            end
            if (c < 10) begin
                drive_b(4'b0000, rd[c], sr[c], pc[c]);
                sb_q.push_back(ex[c]);
            end
        end
    endtask

    // Reset while a redirect is pending must discard it
    task automatic test_reset_pend();
        logic       rs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] st [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [7:0] cb [4] = '{8'b1111_0000, 8'h00, 8'h00, 8'h00};
        exp_t       ex [4] = '{'{1'b0, 32'h240, 4'b0000, 1'b1}, '{1'b0, 32'h0, 4'b0000, 1'b0},
                              '{1'b0, 32'h0, 4'b0000, 1'b0}, '{1'b0, 32'h0, 4'b0000, 1'b0}};
        exp_t e, obs;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb_q.pop_front();
                obs = '{jumpe_a, jpc_a, flush_o_a, busy_a};
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL reset_pend c%0d: got %h expected %h", c, obs, e);
                end
            end
            if (c < 4) begin
                rst_n = rs[c];
                drive_a(st[c], (c == 0), 3'd1, 32'h500);
                sb_q.push_back(ex[c]);
                #1;
                n_checks++;
                if ({stall_o_a, bubble_o_a} !== cb[c]) begin
                    n_fail++;
                    $display("FAIL reset_pend_comb c%0d: got %b expected %b", c, {stall_o_a, bubble_o_a}, cb[c]);
                end
            end
        end
    endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    task automatic test_perf_counters();
        logic [3:0] st [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic       rd [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        n_checks++;
        if ({scnt_a, fcnt_a} !== 64'h0) begin
            n_fail++;
            $display("FAIL perf_init: got stall=%0d flush=%0d expected 0 0", scnt_a, fcnt_a);
        end
        for (int c = 0; c < 10; c++) begin
            drive_a(st[c], rd[c], 3'd1, 32'h10 + 32'(c));
            @(negedge clk);
        end
        n_checks++;
        if (scnt_a !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_stall_cnt: got %0d expected 5", scnt_a);
        end
        n_checks++;
        if (fcnt_a !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_flush_cnt: got %0d expected 2", fcnt_a);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive_a(4'b0000, 1'b0, 3'd0, 32'h0);
        drive_b(4'b0000, 1'b0, 3'd0, 32'h0);
        test_reset();
        test_redirect();
        test_stall();
        test_pend();
        test_flush_multi();
        test_reset_pend();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
